scheduler2_alu_rsv_station: RTL

- ALU reservation station that sits directly downstream of the scheduler's RS allocator. One instance serves RS1 and another serves RS2.
- Accepts up to two allocated instructions per cycle, holds them in age order, and tracks source-operand readiness via wakeup tags.
- Issues the oldest ready entry to the ALU pipe, one per cycle.
- Reports its occupancy on oCOUNT, which feeds the allocator's iRS1_COUNT/iRS2_COUNT load-balancing inputs.

---
 rtl/scheduler2_alu_rsv_station.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/scheduler2_alu_rsv_station.sv
// ALU reservation station: compacting age-ordered queue with wakeup tracking
// and an oldest-ready-first issue register feeding the ALU pipe.
module scheduler2_alu_rsv_station #(
    parameter int P_ENTRY     = 8,
    parameter int P_TAG_W     = 6,
    parameter int P_PAYLOAD_W = 64
) (
    input  logic                   iCLOCK,
    input  logic                   inRESET,
    input  logic                   iFLUSH,
    input  logic                   iWR_0_VALID,
    input  logic [P_PAYLOAD_W-1:0] iWR_0_PAYLOAD,
    input  logic [P_TAG_W-1:0]     iWR_0_SRCA_TAG,
    input  logic [P_TAG_W-1:0]     iWR_0_SRCB_TAG,
    input  logic                   iWR_0_SRCA_RDY,
    input  logic                   iWR_0_SRCB_RDY,
    input  logic                   iWR_1_VALID,
    input  logic [P_PAYLOAD_W-1:0] iWR_1_PAYLOAD,
    input  logic [P_TAG_W-1:0]     iWR_1_SRCA_TAG,
    input  logic [P_TAG_W-1:0]     iWR_1_SRCB_TAG,
    input  logic                   iWR_1_SRCA_RDY,
    input  logic                   iWR_1_SRCB_RDY,
    input  logic                   iWAKEUP_0_VALID,
    input  logic [P_TAG_W-1:0]     iWAKEUP_0_TAG,
    input  logic                   iWAKEUP_1_VALID,
    input  logic [P_TAG_W-1:0]     iWAKEUP_1_TAG,
    input  logic                   iISSUE_LOCK,
    output logic                   oISSUE_VALID,
    output logic [P_PAYLOAD_W-1:0] oISSUE_PAYLOAD,
    output logic [3:0]             oCOUNT,
    output logic                   oFULL,
    output logic                   oOVERFLOW
);

    typedef struct packed {
        logic [P_PAYLOAD_W-1:0] payload;
        logic [P_TAG_W-1:0]     taga;
        logic                   rdya;
        logic [P_TAG_W-1:0]     tagb;
        logic                   rdyb;
    } entry_t;

    entry_t q     [P_ENTRY];
    entry_t woke  [P_ENTRY];
    entry_t sh    [P_ENTRY];
    entry_t nq    [P_ENTRY];
    entry_t w0;
    entry_t w1;

    logic                   sel_found;
    logic [3:0]             sel_idx;
    logic [P_PAYLOAD_W-1:0] sel_payload;
    logic                   issue;
    logic [3:0]             cnt_after;
    logic [3:0]             free_cnt;
    logic [3:0]             idx1;
    logic                   acc0;
    logic                   acc1;
    logic                   drop;
    logic [3:0]             count_next;

    function automatic logic hit(input logic [P_TAG_W-1:0] tag,
                                 input logic v0, input logic [P_TAG_W-1:0] t0,
                                 input logic v1, input logic [P_TAG_W-1:0] t1);
        return (v0 && (t0 == tag)) || (v1 && (t1 == tag));
    endfunction

    always_comb begin
        sel_found   = 1'b0;
        sel_idx     = '0;
        sel_payload = '0;
        // Descending scan so the lowest ready index wins.
        for (int i = P_ENTRY - 1; i >= 0; i--) begin
            if ((4'(i) < oCOUNT) && q[i].rdya && q[i].rdyb) begin
                sel_found   = 1'b1;
                sel_idx     = 4'(i);
                sel_payload = q[i].payload;
            end
        end
        issue = sel_found && !iISSUE_LOCK;

        for (int i = 0; i < P_ENTRY; i++) begin
            woke[i]      = q[i];
            woke[i].rdya = q[i].rdya | hit(q[i].taga, iWAKEUP_0_VALID, iWAKEUP_0_TAG,
                                           iWAKEUP_1_VALID, iWAKEUP_1_TAG);
            woke[i].rdyb = q[i].rdyb | hit(q[i].tagb, iWAKEUP_0_VALID, iWAKEUP_0_TAG,
                                           iWAKEUP_1_VALID, iWAKEUP_1_TAG);
        end
        for (int i = 0; i < P_ENTRY - 1; i++) begin
            sh[i] = (issue && (4'(i) >= sel_idx)) ? woke[i+1] : woke[i];
        end
        sh[P_ENTRY-1] = woke[P_ENTRY-1];

        w0 = '{payload: iWR_0_PAYLOAD, taga: iWR_0_SRCA_TAG, tagb: iWR_0_SRCB_TAG,
               rdya: iWR_0_SRCA_RDY | hit(iWR_0_SRCA_TAG, iWAKEUP_0_VALID, iWAKEUP_0_TAG,
                                          iWAKEUP_1_VALID, iWAKEUP_1_TAG),
               rdyb: iWR_0_SRCB_RDY | hit(iWR_0_SRCB_TAG, iWAKEUP_0_VALID, iWAKEUP_0_TAG,
                                          iWAKEUP_1_VALID, iWAKEUP_1_TAG)};
        w1 = '{payload: iWR_1_PAYLOAD, taga: iWR_1_SRCA_TAG, tagb: iWR_1_SRCB_TAG,
               rdya: iWR_1_SRCA_RDY | hit(iWR_1_SRCA_TAG, iWAKEUP_0_VALID, iWAKEUP_0_TAG,
                                          iWAKEUP_1_VALID, iWAKEUP_1_TAG),
               rdyb: iWR_1_SRCB_RDY | hit(iWR_1_SRCB_TAG, iWAKEUP_0_VALID, iWAKEUP_0_TAG,
                                          iWAKEUP_1_VALID, iWAKEUP_1_TAG)};

        // Space freed by this cycle's issue is usable by this cycle's writes.
        cnt_after  = oCOUNT - {3'b000, issue};
        free_cnt   = 4'(P_ENTRY) - cnt_after;
        acc0       = iWR_0_VALID && (free_cnt != 4'd0);
        acc1       = iWR_1_VALID && (free_cnt > {3'b000, acc0});
        idx1       = cnt_after + {3'b000, acc0};
        drop       = (iWR_0_VALID && !acc0) || (iWR_1_VALID && !acc1);
        count_next = cnt_after + {3'b000, acc0} + {3'b000, acc1};

        for (int i = 0; i < P_ENTRY; i++) begin
            nq[i] = sh[i];
            if (acc0 && (4'(i) == cnt_after)) nq[i] = w0;
            if (acc1 && (4'(i) == idx1))      nq[i] = w1;
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (!inRESET || iFLUSH) begin
            oCOUNT         <= 4'd0;
            oISSUE_VALID   <= 1'b0;
            oISSUE_PAYLOAD <= '0;
            oOVERFLOW      <= 1'b0;
        end else begin
            oCOUNT <= count_next;
            if (!iISSUE_LOCK) begin
                oISSUE_VALID <= sel_found;
                if (sel_found) oISSUE_PAYLOAD <= sel_payload;
            end
            if (drop) oOVERFLOW <= 1'b1;
        end
    end

    // Entry contents need no reset: validity is defined solely by oCOUNT.
    always_ff @(posedge iCLOCK) begin
        q <= nq;
    end

    assign oFULL = (oCOUNT >= 4'(P_ENTRY - 1));

endmodule
